// File: rtl/gnw_rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module : gnw_rtc_pkg
// Brief  : Shared types, layout indices and time conversions for the RTC sync.
// Rev    : 1.0
// ============================================================================
package gnw_rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_ACC = 3'd1,
        ST_RD_ACC = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_DONE   = 3'd4
    } rtc_state_e;

    localparam int RTC_NIBBLES = 6;

    localparam logic [2:0] IDX_HT = 3'd0;
    localparam logic [2:0] IDX_HU = 3'd1;
    localparam logic [2:0] IDX_MT = 3'd2;
    localparam logic [2:0] IDX_MU = 3'd3;
    localparam logic [2:0] IDX_ST = 3'd4;
    localparam logic [2:0] IDX_SU = 3'd5;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        return 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = bin / 7'd10;
        units = bin % 7'd10;
        return {tens[3:0], units[3:0]};
    endfunction

    // Returns {pm, hour12}.
    function automatic logic [4:0] hour24_to_12(input logic [4:0] h24);
        if (h24 == 5'd0)  return {1'b0, 4'd12};
        if (h24 < 5'd12)  return {1'b0, h24[3:0]};
        if (h24 == 5'd12) return {1'b1, 4'd12};
        return {1'b1, 4'(h24 - 5'd12)};
    endfunction

    // Returns {err, hour24}; out-of-range hour12 yields err with hour 0.
    function automatic logic [5:0] hour12_to_24(input logic pm, input logic [5:0] h12);
        if (h12 == 6'd0 || h12 > 6'd12) return 6'b100000;
        if (h12 == 6'd12)               return pm ? 6'd12 : 6'd0;
        return pm ? {1'b0, 5'(h12 + 6'd12)} : {1'b0, h12[4:0]};
    endfunction

    function automatic logic hms_valid(input logic [23:0] t);
        logic ok;
        ok = (t[23:16] <= 8'h23) && (t[15:12] <= 4'd5) && (t[7:4] <= 4'd5);
        for (int i = 0; i < RTC_NIBBLES; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnw_rtc_hourconv.sv
`default_nettype none
// ============================================================================
// Module : gnw_rtc_hourconv
// Brief  : 24h BCD hour <-> SM510 {PM,0,tens[1:0]} / units nibble pair.
// Rev    : 1.0
// ============================================================================
module gnw_rtc_hourconv
    import gnw_rtc_pkg::*;
(
    input  logic [7:0] h24_bcd_i,
    output logic [3:0] nib_ht_o,
    output logic [3:0] nib_hu_o,
    input  logic [3:0] rd_ht_i,
    input  logic [3:0] rd_hu_i,
    output logic [7:0] h24_bcd_o,
    output logic       err_o
);
    logic [6:0] w_h24_bin;
    logic [4:0] w_h12;
    logic [7:0] w_h12_bcd;
    logic [5:0] w_rd_h12;
    logic [5:0] w_rd_res;
    logic       w_unused;

    always_comb begin
        w_h24_bin = bcd_to_bin(h24_bcd_i);
        w_h12     = hour24_to_12(w_h24_bin[4:0]);
        w_h12_bcd = bin_to_bcd({3'b000, w_h12[3:0]});
        nib_ht_o  = {w_h12[4], 1'b0, w_h12_bcd[5:4]};
        nib_hu_o  = w_h12_bcd[3:0];
    end

    // A units nibble above 9 is not a legal hour either.
    always_comb begin
        w_rd_h12  = 6'(rd_ht_i[1:0]) * 6'd10 + 6'(rd_hu_i);
        w_rd_res  = hour12_to_24(rd_ht_i[3], w_rd_h12);
        err_o     = w_rd_res[5] | (rd_hu_i > 4'd9);
        h24_bcd_o = err_o ? 8'h00 : bin_to_bcd({2'b00, w_rd_res[4:0]});
    end

    assign w_unused = ^{w_h24_bin[6:5], w_h12_bcd[7:6], rd_ht_i[2]};

endmodule
`default_nettype wire

// File: rtl/gnw_rtc_sync.sv
`default_nettype none
// ============================================================================
// Module : gnw_rtc_sync
// Brief  : Moves host HHMMSS to/from the six-nibble SM510 RAM clock area.
// Rev    : 1.0
// ============================================================================
module gnw_rtc_sync
    import gnw_rtc_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int GNT_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_time,
    input  logic              read_time,
    input  logic [23:0]       hms_in,
    input  logic [ADDR_W-1:0] hms_loc,
    output logic [23:0]       hms_out,
    output logic              hms_rdy,
    output logic              hms_err,
    output logic              busy,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata
);
    localparam int              c_CNT_W    = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(GNT_TIMEOUT - 1);

    rtc_state_e          state_q;
    logic [2:0]          idx_q;
    logic [ADDR_W-1:0]   loc_q;
    logic [23:0]         hms_q;
    logic [23:0]         rbuf_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic                pend_wr_q, pend_rd_q, pend_wr_d, pend_rd_d;
    logic                wr_prev_q, rd_prev_q;
    logic                dir_rd_q;
    logic [23:0]         hms_out_q;
    logic                rdy_q, err_q, busy_q;

    logic                w_want_wr, w_want_rd, w_acc_wr, w_acc_rd;
    logic                w_timeout, w_last;
    logic [3:0]          w_nib_ht, w_nib_hu, w_nib;
    logic [7:0]          w_conv_h24;
    logic                w_conv_err;

    gnw_rtc_hourconv u_hourconv (
        .h24_bcd_i (hms_q[23:16]),
        .nib_ht_o  (w_nib_ht),
        .nib_hu_o  (w_nib_hu),
        .rd_ht_i   (rbuf_q[23:20]),
        .rd_hu_i   (rbuf_q[19:16]),
        .h24_bcd_o (w_conv_h24),
        .err_o     (w_conv_err)
    );

    assign ram_req   = (state_q == ST_WR_ACC) || (state_q == ST_RD_ACC);
    assign ram_we    = (state_q == ST_WR_ACC);
    assign ram_addr  = loc_q + ADDR_W'(idx_q);
    assign ram_wdata = ram_we ? w_nib : 4'h0;
    assign hms_out   = hms_out_q;
    assign hms_rdy   = rdy_q;
    assign hms_err   = err_q;
    assign busy      = busy_q;

    always_comb begin
        w_nib = 4'h0;
        case (idx_q)
            IDX_HT:  w_nib = w_nib_ht;
            IDX_HU:  w_nib = w_nib_hu;
            IDX_MT:  w_nib = hms_q[15:12];
            IDX_MU:  w_nib = hms_q[11:8];
            IDX_ST:  w_nib = hms_q[7:4];
            IDX_SU:  w_nib = hms_q[3:0];
            default: w_nib = 4'h0;
        endcase
    end

    // An edge seen in IDLE is accepted at once; otherwise it waits one deep.
    always_comb begin
        w_want_wr = pend_wr_q | (write_time & ~wr_prev_q);
        w_want_rd = pend_rd_q | (read_time & ~rd_prev_q);
        w_acc_wr  = (state_q == ST_IDLE) & w_want_wr;
        w_acc_rd  = (state_q == ST_IDLE) & ~w_want_wr & w_want_rd;
        w_timeout = ram_req & ~ram_gnt & (cnt_q == c_CNT_LAST);
        w_last    = (idx_q == 3'(RTC_NIBBLES - 1));
        pend_wr_d = w_want_wr & ~w_acc_wr & ~(w_timeout & (state_q == ST_WR_ACC));
        pend_rd_d = w_want_rd & ~w_acc_rd & ~(w_timeout & (state_q == ST_RD_ACC));
    end

    always_ff @(posedge clk) begin
        wr_prev_q <= write_time;
        rd_prev_q <= read_time;
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            loc_q     <= '0;
            hms_q     <= 24'h0;
            rbuf_q    <= 24'h0;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            dir_rd_q  <= 1'b0;
            hms_out_q <= 24'h0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            rdy_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idx_q <= 3'd0;
                    cnt_q <= '0;
                    loc_q <= hms_loc;
                    if (w_acc_wr) begin
                        hms_q    <= hms_in;
                        dir_rd_q <= 1'b0;
                        busy_q   <= 1'b1;
                        err_q    <= ~hms_valid(hms_in);
                        state_q  <= hms_valid(hms_in) ? ST_WR_ACC : ST_DONE;
                    end else if (w_acc_rd) begin
                        dir_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= ST_RD_ACC;
                    end
                end
                ST_WR_ACC, ST_RD_ACC: begin
                    if (ram_gnt) begin
                        cnt_q <= '0;
                        if (state_q == ST_RD_ACC) begin
                            state_q <= ST_RD_CAP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            if (w_last) state_q <= ST_DONE;
                        end
                    end else if (w_timeout) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                ST_RD_CAP: begin
                    rbuf_q  <= {rbuf_q[19:0], ram_rdata};
                    idx_q   <= idx_q + 3'd1;
                    state_q <= w_last ? ST_DONE : ST_RD_ACC;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    if (dir_rd_q) begin
                        hms_out_q <= {w_conv_h24, rbuf_q[15:0]};
                        if (w_conv_err) err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gnw_rtc_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_gnw_rtc_sync
// Brief  : Directed self-checking bench for gnw_rtc_sync with a nibble RAM model.
// Rev    : 1.0
// ============================================================================
module tb_gnw_rtc_sync;
    localparam int ADDR_W = 7;
    localparam int GNT_TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              write_time = 1'b0;
    logic              read_time = 1'b0;
    logic [23:0]       hms_in = 24'h0;
    logic [ADDR_W-1:0] hms_loc = '0;
    logic [23:0]       hms_out;
    logic              hms_rdy, hms_err, busy;
    logic              ram_req, ram_we;
    logic              ram_gnt = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wdata;
    logic [3:0]        ram_rdata = 4'h0;

    logic [3:0] mem [128];
    logic       mem_clr = 1'b1;
    int         gnt_mode = 1;
    int         n_chk = 0, n_err = 0;
    int         req_cnt = 0, rdy_cnt = 0, stab_viol = 0, order_viol = 0;
    logic       rd_seen = 1'b0;
    logic       prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [3:0] prev_wdata = 4'h0;

    gnw_rtc_sync #(.ADDR_W(ADDR_W), .GNT_TIMEOUT(GNT_TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_time (write_time),
        .read_time  (read_time),
        .hms_in     (hms_in),
        .hms_loc    (hms_loc),
        .hms_out    (hms_out),
        .hms_rdy    (hms_rdy),
        .hms_err    (hms_err),
        .busy       (busy),
        .ram_req    (ram_req),
        .ram_gnt    (ram_gnt),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 4'hF;
        end else if (ram_req && ram_gnt) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       ram_gnt = 1'b0;
                1:       ram_gnt = 1'b1;
                default: ram_gnt = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    // Bus observer: request/pulse counts, stall stability, write-before-read order.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_req) req_cnt++;
            if (hms_rdy) rdy_cnt++;
            if (prev_req && !prev_gnt && ram_req &&
                (ram_addr != prev_addr || ram_wdata != prev_wdata || ram_we != prev_we))
                stab_viol++;
            if (ram_req && ram_gnt) begin
                if (ram_we && rd_seen) order_viol++;
                if (!ram_we) rd_seen = 1'b1;
            end
            prev_req   = ram_req;
            prev_gnt   = ram_gnt;
            prev_we    = ram_we;
            prev_addr  = ram_addr;
            prev_wdata = ram_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] mem6(input logic [ADDR_W-1:0] base);
        logic [23:0] r;
        r = 24'h0;
        for (int i = 0; i < 6; i++) r = {r[19:0], mem[ADDR_W'(base + ADDR_W'(i))]};
        return r;
    endfunction

    // Raise one request level and count negedges until hms_rdy.
    task automatic xfer(input logic rd, input logic [23:0] t, input logic [ADDR_W-1:0] loc,
                        output int lat);
        hms_in  = t;
        hms_loc = loc;
        if (rd) read_time = 1'b1;
        else    write_time = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            write_time = 1'b0;
            read_time  = 1'b0;
        end while (!hms_rdy && lat < 400);
    endtask

    initial begin
        int lat;
        int r0;
        repeat (3) @(negedge clk);
        chk("rst_req",   ram_req, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_rdy",   hms_rdy, 0);
        chk("rst_err",   hms_err, 0);
        chk("rst_out",   hms_out, 0);
        chk("rst_bus",   {ram_we, ram_addr, ram_wdata}, 0);
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        repeat (2) @(negedge clk);

        // 13:45:27 -> 1 PM: {1,0,00}=8, 1
        xfer(1'b0, 24'h134527, 7'h10, lat);
        chk("w1_lat",  lat, 8);
        chk("w1_err",  hms_err, 0);
        chk("w1_busy", busy, 0);
        chk("w1_mem",  mem6(7'h10), 24'h814527);
        @(negedge clk);
        chk("w1_rdy_pulse", hms_rdy, 0);
        xfer(1'b1, 24'h0, 7'h10, lat);
        chk("r1_lat", lat, 14);
        chk("r1_out", hms_out, 24'h134527);
        chk("r1_err", hms_err, 0);

        // midnight -> 12 AM
        xfer(1'b0, 24'h000000, 7'h20, lat);
        chk("w2_mem", mem6(7'h20), 24'h120000);
        xfer(1'b1, 24'h0, 7'h20, lat);
        chk("r2_out", hms_out, 24'h000000);

        // noon across the 7F->00 wrap
        xfer(1'b0, 24'h120000, 7'h7D, lat);
        chk("w3_wrap_mem", mem6(7'h7D), 24'h920000);
        xfer(1'b1, 24'h0, 7'h7D, lat);
        chk("r3_out", hms_out, 24'h120000);

        // 23:59:59 -> 11 PM
        xfer(1'b0, 24'h235959, 7'h30, lat);
        chk("w4_mem", mem6(7'h30), 24'h915959);
        xfer(1'b1, 24'h0, 7'h30, lat);
        chk("r4_out", hms_out, 24'h235959);

        // invalid hour, then invalid nibble
        req_cnt = 0;
        xfer(1'b0, 24'h246000, 7'h50, lat);
        chk("bad1_lat", lat, 2);
        chk("bad1_err", hms_err, 1);
        repeat (3) @(negedge clk);
        chk("bad1_sticky", hms_err, 1);
        xfer(1'b0, 24'h1A0000, 7'h50, lat);
        chk("bad2_err", hms_err, 1);
        chk("bad_noreq", req_cnt, 0);
        chk("bad_mem", mem6(7'h50), 24'hFFFFFF);

        // simultaneous write+read with random grants
        gnt_mode   = 2;
        rd_seen    = 1'b0;
        order_viol = 0;
        r0         = rdy_cnt;
        hms_in     = 24'h091530;
        hms_loc    = 7'h40;
        write_time = 1'b1;
        read_time  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            write_time = 1'b0;
            read_time  = 1'b0;
        end while ((rdy_cnt - r0) < 2 && lat < 2000);
        chk("sim_done",  rdy_cnt - r0, 2);
        chk("sim_order", order_viol, 0);
        chk("sim_mem",   mem6(7'h40), 24'h091530);
        chk("sim_out",   hms_out, 24'h091530);
        chk("sim_err",   hms_err, 0);
        chk("stable",    stab_viol, 0);

        // grant never arrives
        @(negedge clk);
        gnt_mode = 0;
        req_cnt  = 0;
        xfer(1'b1, 24'h0, 7'h10, lat);
        chk("to_lat", lat, GNT_TO + 1);
        chk("to_req", ram_req, 0);
        chk("to_err", hms_err, 1);
        chk("to_out", hms_out, 24'h091530);
        repeat (5) @(negedge clk);
        chk("to_reqcnt", req_cnt, GNT_TO);
        chk("to_busy", busy, 0);

        // reset in the middle of a read; write_time held high through reset
        gnt_mode  = 1;
        read_time = 1'b1;
        @(negedge clk);
        read_time = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        rst_n      = 1'b0;
        write_time = 1'b1;
        r0         = rdy_cnt;
        @(negedge clk);
        chk("mid_req",  ram_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_err",  hms_err, 0);
        rst_n   = 1'b1;
        req_cnt = 0;
        repeat (20) @(negedge clk);
        chk("mid_no_rdy",  rdy_cnt - r0, 0);
        chk("held_no_req", req_cnt, 0);
        write_time = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
